// File: rtl/serial_divider_wb_master.sv
// serial_divider_wb_master
// Wishbone classic initiator for the serial divider slave. A request on the
// valid/ready port triggers: write DIVIDEND, write DIVISOR, write CTRL.start,
// poll STATUS.done, read QUOTIENT, read REMAINDER, then present the result
// on the valid/ready response port. Every bus access is followed by a
// single idle (GAP) cycle with cyc/stb low.
// Optional feature macro: SERIAL_DIVIDER_WBM_TIMEOUT_EN adds an ack/poll
// timeout counter that aborts the sequence and returns err_o = 1.
module serial_divider_wb_master #(
  parameter int unsigned    WBW      = 32,
  parameter int unsigned    XLEN     = 32,
  parameter logic [WBW-1:0] BASE_ADR = 32'h3000_0000,
  parameter int unsigned    TMO_CYC  = 1024
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [XLEN-1:0]  dividend_i,
  input  logic [XLEN-1:0]  divisor_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [XLEN-1:0]  quotient_o,
  output logic [XLEN-1:0]  remainder_o,
  output logic             err_o,
  output logic             busy_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [WBW/8-1:0] wbm_sel_o,
  output logic [WBW-1:0]   wbm_adr_o,
  output logic [WBW-1:0]   wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [WBW-1:0]   wbm_dat_i
);

  localparam logic [WBW-1:0] ADR_DVD  = BASE_ADR;
  localparam logic [WBW-1:0] ADR_DVS  = BASE_ADR + WBW'(4);
  localparam logic [WBW-1:0] ADR_CTRL = BASE_ADR + WBW'(8);
  localparam logic [WBW-1:0] ADR_STAT = BASE_ADR + WBW'(12);
  localparam logic [WBW-1:0] ADR_QUO  = BASE_ADR + WBW'(16);
  localparam logic [WBW-1:0] ADR_REM  = BASE_ADR + WBW'(20);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_DVD, S_WR_DVS, S_WR_CTRL, S_RD_STAT, S_RD_QUO, S_RD_REM, S_RESP
  } state_t;

  state_t          state_reg, state_next;
  logic            cyc_reg, cyc_next;
  logic            stb_reg, stb_next;
  logic            we_reg, we_next;
  logic [WBW-1:0]  adr_reg, adr_next;
  logic [WBW-1:0]  dat_reg, dat_next;
  logic            req_ready_reg, req_ready_next;
  logic            busy_reg, busy_next;
  logic            rsp_valid_reg, rsp_valid_next;
  logic [XLEN-1:0] quotient_reg, quotient_next;
  logic [XLEN-1:0] remainder_reg, remainder_next;
  logic [XLEN-1:0] dividend_reg, dividend_next;
  logic [XLEN-1:0] divisor_reg, divisor_next;

  // Access parameters of the bus state currently held in state_reg
  logic            iss_we;
  logic [WBW-1:0]  iss_adr;
  logic [WBW-1:0]  iss_dat;

`ifdef SERIAL_DIVIDER_WBM_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);
  logic             err_reg, err_next;
  logic [TMO_W-1:0] tmo_reg, tmo_next;
`endif

  // Byte selects are always all ones
  genvar gi;
  generate
    for (gi = 0; gi < WBW / 8; gi++) begin : g_sel
      assign wbm_sel_o[gi] = 1'b1;
    end
  endgenerate

  // Address/direction/data for the access belonging to the current bus state
  always_comb begin
    iss_we  = 1'b1;
    iss_adr = ADR_DVD;
    iss_dat = '0;
    case (state_reg)
      S_WR_DVD:  begin iss_adr = ADR_DVD;  iss_dat = WBW'(dividend_reg); end
      S_WR_DVS:  begin iss_adr = ADR_DVS;  iss_dat = WBW'(divisor_reg);  end
      S_WR_CTRL: begin iss_adr = ADR_CTRL; iss_dat = WBW'(1);            end
      S_RD_STAT: begin iss_adr = ADR_STAT; iss_we = 1'b0;                end
      S_RD_QUO:  begin iss_adr = ADR_QUO;  iss_we = 1'b0;                end
      S_RD_REM:  begin iss_adr = ADR_REM;  iss_we = 1'b0;                end
      default:   ;
    endcase
  end

  // Next-state and next-output logic; cyc_reg low inside a bus state is the GAP
  always_comb begin
    state_next     = state_reg;
    cyc_next       = cyc_reg;
    stb_next       = stb_reg;
    we_next        = we_reg;
    adr_next       = adr_reg;
    dat_next       = dat_reg;
    rsp_valid_next = rsp_valid_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dividend_next  = dividend_reg;
    divisor_next   = divisor_reg;
`ifdef SERIAL_DIVIDER_WBM_TIMEOUT_EN
    err_next       = err_reg;
    tmo_next       = tmo_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (req_valid_i && req_ready_reg) begin
          dividend_next = dividend_i;
          divisor_next  = divisor_i;
          state_next    = S_WR_DVD;
          cyc_next      = 1'b1;
          stb_next      = 1'b1;
          we_next       = 1'b1;
          adr_next      = ADR_DVD;
          dat_next      = WBW'(dividend_i);
`ifdef SERIAL_DIVIDER_WBM_TIMEOUT_EN
          tmo_next      = '0;
`endif
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_next = 1'b0;
          state_next     = S_IDLE;
`ifdef SERIAL_DIVIDER_WBM_TIMEOUT_EN
          err_next       = 1'b0;
`endif
        end
      end
      default: begin
        if (!cyc_reg) begin
          // GAP cycle over: launch this state's access
          cyc_next = 1'b1;
          stb_next = 1'b1;
          we_next  = iss_we;
          adr_next = iss_adr;
          dat_next = iss_dat;
        end else if (wbm_ack_i) begin
          cyc_next = 1'b0;
          stb_next = 1'b0;
`ifdef SERIAL_DIVIDER_WBM_TIMEOUT_EN
          // Polls share one budget, so a not-done STATUS keeps the count
          if (!(state_reg == S_RD_STAT && !wbm_dat_i[0])) tmo_next = '0;
`endif
          case (state_reg)
            S_WR_DVD:  state_next = S_WR_DVS;
            S_WR_DVS:  state_next = S_WR_CTRL;
            S_WR_CTRL: state_next = S_RD_STAT;
            S_RD_STAT: if (wbm_dat_i[0]) state_next = S_RD_QUO;
            S_RD_QUO: begin
              quotient_next = wbm_dat_i[XLEN-1:0];
              state_next    = S_RD_REM;
            end
            S_RD_REM: begin
              remainder_next = wbm_dat_i[XLEN-1:0];
              rsp_valid_next = 1'b1;
              state_next     = S_RESP;
            end
            default: ;
          endcase
        end
`ifdef SERIAL_DIVIDER_WBM_TIMEOUT_EN
        else if (tmo_reg == TMO_W'(TMO_CYC - 1)) begin
          // Budget exhausted: abandon the bus and report an error result
          cyc_next       = 1'b0;
          stb_next       = 1'b0;
          quotient_next  = '0;
          remainder_next = '0;
          err_next       = 1'b1;
          rsp_valid_next = 1'b1;
          state_next     = S_RESP;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
`endif
      end
    endcase
    req_ready_next = (state_next == S_IDLE);
    busy_next      = (state_next != S_IDLE);
  end

  // State and registered outputs; reset drops the bus and discards any result
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_reg     <= S_IDLE;
      cyc_reg       <= 1'b0;
      stb_reg       <= 1'b0;
      we_reg        <= 1'b0;
      adr_reg       <= '0;
      dat_reg       <= '0;
      req_ready_reg <= 1'b1;
      busy_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dividend_reg  <= '0;
      divisor_reg   <= '0;
`ifdef SERIAL_DIVIDER_WBM_TIMEOUT_EN
      err_reg       <= 1'b0;
      tmo_reg       <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      cyc_reg       <= cyc_next;
      stb_reg       <= stb_next;
      we_reg        <= we_next;
      adr_reg       <= adr_next;
      dat_reg       <= dat_next;
      req_ready_reg <= req_ready_next;
      busy_reg      <= busy_next;
      rsp_valid_reg <= rsp_valid_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dividend_reg  <= dividend_next;
      divisor_reg   <= divisor_next;
`ifdef SERIAL_DIVIDER_WBM_TIMEOUT_EN
      err_reg       <= err_next;
      tmo_reg       <= tmo_next;
`endif
    end
  end

  assign wbm_cyc_o   = cyc_reg;
  assign wbm_stb_o   = stb_reg;
  assign wbm_we_o    = we_reg;
  assign wbm_adr_o   = adr_reg;
  assign wbm_dat_o   = dat_reg;
  assign req_ready_o = req_ready_reg;
  assign busy_o      = busy_reg;
  assign rsp_valid_o = rsp_valid_reg;
  assign quotient_o  = quotient_reg;
  assign remainder_o = remainder_reg;
`ifdef SERIAL_DIVIDER_WBM_TIMEOUT_EN
  assign err_o       = err_reg;
`else
  assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_serial_divider_wb_master.sv
// Testbench for serial_divider_wb_master: a behavioural divider slave with
// configurable ack latency and poll count, a response scoreboard, and a bus
// monitor checking access order, hold stability and GAP cycles.
module tb_serial_divider_wb_master;

  localparam logic [31:0] ADR_DVD  = 32'h3000_0000;
  localparam logic [31:0] ADR_DVS  = 32'h3000_0004;
  localparam logic [31:0] ADR_CTRL = 32'h3000_0008;
  localparam logic [31:0] ADR_STAT = 32'h3000_000C;
  localparam logic [31:0] ADR_QUO  = 32'h3000_0010;
  localparam logic [31:0] ADR_REM  = 32'h3000_0014;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] quotient, remainder;
  logic        err, busy;
  logic        wbm_cyc, wbm_stb, wbm_we, wbm_ack;
  logic [3:0]  wbm_sel;
  logic [31:0] wbm_adr, wbm_dat_o, wbm_dat_i;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] q; logic [31:0] r; logic e; } rsp_t;
  typedef struct { logic [31:0] adr; logic we; logic [31:0] dat; } bus_t;
  rsp_t exp_rsp[$];
  bus_t exp_bus[$];

  // Slave model state
  int          lat = 0;
  int          polls_needed = 0;
  logic [31:0] no_ack_adr = 32'hFFFF_FFFF;
  int          wait_cnt = 0;
  int          poll_cnt = 0;
  logic [31:0] s_dvd = '0, s_dvs = '0, s_q = '0, s_r = '0;

  int stat_reads = 0;
  int dvs_stb_cnt = 0;

  serial_divider_wb_master #(.TMO_CYC(16)) dut (
    .clk_i(clk), .reset_ni(reset_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .dividend_i(dividend), .divisor_i(divisor),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .quotient_o(quotient), .remainder_o(remainder),
    .err_o(err), .busy_o(busy),
    .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_we_o(wbm_we),
    .wbm_sel_o(wbm_sel), .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack), .wbm_dat_i(wbm_dat_i)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Divider slave: ack after lat wait cycles, STATUS done after polls_needed polls
  assign wbm_ack = wbm_cyc && wbm_stb && (wait_cnt == lat) && (wbm_adr != no_ack_adr);

  always_comb begin
    wbm_dat_i = '0;
    case (wbm_adr)
      ADR_STAT: wbm_dat_i = {31'b0, poll_cnt >= polls_needed};
      ADR_QUO:  wbm_dat_i = s_q;
      ADR_REM:  wbm_dat_i = s_r;
      default:  wbm_dat_i = '0;
    endcase
  end

  always @(posedge clk) begin
    if (wbm_cyc && wbm_stb && !wbm_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (wbm_ack) begin
      if (wbm_we) begin
        if (wbm_adr == ADR_DVD) s_dvd <= wbm_dat_o;
        if (wbm_adr == ADR_DVS) s_dvs <= wbm_dat_o;
        if (wbm_adr == ADR_CTRL && wbm_dat_o[0]) begin
          s_q      <= (s_dvs == 0) ? 32'hFFFF_FFFF : s_dvd / s_dvs;
          s_r      <= (s_dvs == 0) ? s_dvd : s_dvd % s_dvs;
          poll_cnt <= 0;
        end
      end else if (wbm_adr == ADR_STAT) begin
        poll_cnt <= poll_cnt + 1;
      end
    end
  end

  // Response monitor: pop scoreboard on each response handshake
  initial forever begin
    @(negedge clk);
    if (reset_n && rsp_valid && rsp_ready) begin
      if (exp_rsp.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected: got q=%h r=%h, none expected", quotient, remainder);
      end else begin
        rsp_t e;
        e = exp_rsp.pop_front();
        chk("rsp_quotient", 64'(quotient), 64'(e.q));
        chk("rsp_remainder", 64'(remainder), 64'(e.r));
        chk("rsp_err", 64'(err), 64'(e.e));
        $display("rsp q=%h r=%h err=%0d", quotient, remainder, err);
      end
    end
  end

  // Bus monitor: access order, hold stability while waiting, single GAP cycle
  initial begin
    logic        pend = 1'b0, gap_chk = 1'b0, resume_chk = 1'b0;
    logic [31:0] sv_adr = '0, sv_dat = '0, last_adr = '0;
    logic        sv_we = 1'b0;
    bus_t        b;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pend = 1'b0; gap_chk = 1'b0; resume_chk = 1'b0;
      end else begin
        if (resume_chk) chk("bus_resume", 64'(wbm_cyc), 64'd1);
        resume_chk = 1'b0;
        if (gap_chk) begin
          chk("gap_cyc_stb", 64'({wbm_cyc, wbm_stb}), 64'd0);
          resume_chk = (last_adr != ADR_REM);
          gap_chk = 1'b0;
        end
        if (pend) begin
          chk("hold_adr_we", {31'b0, wbm_we, wbm_adr}, {31'b0, sv_we, sv_adr});
          chk("hold_dat", 64'(wbm_dat_o), 64'(sv_dat));
        end
        if (wbm_cyc && wbm_stb && wbm_adr == ADR_DVS) dvs_stb_cnt++;
        if (wbm_cyc && wbm_stb && wbm_ack) begin
          if (!wbm_we && wbm_adr == ADR_STAT) stat_reads++;
          if (exp_bus.size() > 0) begin
            b = exp_bus.pop_front();
            chk("bus_adr", 64'(wbm_adr), 64'(b.adr));
            chk("bus_we", 64'(wbm_we), 64'(b.we));
            if (b.we) chk("bus_dat", 64'(wbm_dat_o), 64'(b.dat));
          end
          gap_chk = 1'b1;
          last_adr = wbm_adr;
        end
        pend = wbm_cyc && wbm_stb && !wbm_ack;
        sv_adr = wbm_adr; sv_we = wbm_we; sv_dat = wbm_dat_o;
      end
    end
  end

  task automatic push_seq(input logic [31:0] a, input logic [31:0] d, input int polls);
    exp_bus.push_back('{ADR_DVD, 1'b1, a});
    exp_bus.push_back('{ADR_DVS, 1'b1, d});
    exp_bus.push_back('{ADR_CTRL, 1'b1, 32'h1});
    for (int i = 0; i <= polls; i++) exp_bus.push_back('{ADR_STAT, 1'b0, 32'h0});
    exp_bus.push_back('{ADR_QUO, 1'b0, 32'h0});
    exp_bus.push_back('{ADR_REM, 1'b0, 32'h0});
  endtask

  task automatic send_req(input logic [31:0] a, input logic [31:0] d, input logic [31:0] q,
                          input logic [31:0] r, input logic e, input bit push);
    int n = 0;
    if (push) exp_rsp.push_back('{q, r, e});
    @(posedge clk); #1;
    req_valid = 1'b1; dividend = a; divisor = d;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 3000) begin
        checks++; errors++;
        $display("FAIL req_handshake: ready never seen, waited %0d cycles", n);
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_rsp.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    if (exp_rsp.size() != 0) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: %0d responses outstanding, required 0", exp_rsp.size());
      exp_rsp.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cyc_stb_we", 64'({wbm_cyc, wbm_stb, wbm_we}), 64'd0);
    chk("rst_adr", 64'(wbm_adr), 64'd0);
    chk("rst_err_q_r", {31'b0, err, quotient}, 64'd0);
    chk("sel", 64'(wbm_sel), 64'hF);
    reset_n = 1'b1;

    // Single op, done on first poll
    stat_reads = 0;
    push_seq(32'd100, 32'd7, 0);
    send_req(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
    drain();
    chk("t1_stat_reads", 64'(stat_reads), 64'd1);
    chk("t1_bus_seq_done", 64'(exp_bus.size()), 64'd0);

    // Slow divider: 32 not-done polls then done
    polls_needed = 32; stat_reads = 0;
    send_req(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    drain();
    chk("t2_stat_reads", 64'(stat_reads), 64'd33);
    polls_needed = 0;

    // Ack wait states
    lat = 3;
    send_req(32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 1'b1);
    drain();
    lat = 0;

    // Response backpressure
    rsp_ready = 1'b0;
    send_req(32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 1'b1);
    begin
      int n = 0;
      while (!rsp_valid && n < 500) begin @(negedge clk); n++; end
    end
    fork
      send_req(32'd8, 32'd3, 32'd2, 32'd2, 1'b0, 1'b1);
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
          chk("bp_q_r", {quotient, remainder}, {32'd3, 32'd2});
          chk("bp_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
      end
    join
    drain();

    // Reset during RD_STAT
    polls_needed = 1000;
    send_req(32'd50, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    begin
      int n = 0;
      while (!(wbm_cyc && wbm_adr == ADR_STAT) && n < 500) begin @(negedge clk); n++; end
    end
    #2 reset_n = 1'b0;
    #1;
    chk("arst_cyc_stb", 64'({wbm_cyc, wbm_stb}), 64'd0);
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    polls_needed = 0;
    @(negedge clk);
    chk("arst_req_ready", 64'(req_ready), 64'd1);
    chk("arst_busy", 64'(busy), 64'd0);
    push_seq(32'd9, 32'd4, 0);
    send_req(32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 1'b1);
    drain();
    chk("t5_bus_seq_done", 64'(exp_bus.size()), 64'd0);

`ifdef SERIAL_DIVIDER_WBM_TIMEOUT_EN
    // Slave never acks the DIVISOR write
    no_ack_adr = ADR_DVS; dvs_stb_cnt = 0;
    send_req(32'd5, 32'd5, 32'd0, 32'd0, 1'b1, 1'b1);
    drain();
    chk("tmo_stb_cycles", 64'(dvs_stb_cnt), 64'd16);
    no_ack_adr = 32'hFFFF_FFFF;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_divider_wb_master.md
Name: serial_divider_wb_master

Overview:
- Wishbone classic initiator that drives the serial divider project's slave port.
- Accepts a dividend/divisor pair on a valid/ready request port, then runs a fixed sequence of Wishbone cycles: write operands, start, poll status, read results.
- Returns quotient/remainder on a valid/ready response port.
- Sits beside the divider in the user project area. It lets on-chip logic or a test harness exercise the divider without the management SoC.

Parameters:
- WBW, 32, Wishbone data/address width.
- XLEN, 32, operand/result width; must be <= WBW, zero-extended on writes, low XLEN bits taken on reads.
- BASE_ADR, 32'h3000_0000, divider register base address.
- TMO_CYC, 1024, ack timeout in cycles; used only with the optional feature.

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- reset_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  high only in IDLE.
- dividend_i  in  XLEN  dividend, captured on request handshake.
- divisor_i  in  XLEN  divisor, captured on request handshake.
- rsp_valid_o  out  1  result valid.
- rsp_ready_i  in  1  result accepted.
- quotient_o  out  XLEN  quotient.
- remainder_o  out  XLEN  remainder.
- err_o  out  1  result invalid (timeout); tied 0 without the optional feature.
- busy_o  out  1  FSM not IDLE.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  WBW/8  byte selects, always all ones.
- wbm_adr_o  out  WBW  Wishbone address.
- wbm_dat_o  out  WBW  Wishbone write data.
- wbm_ack_i  in  1  Wishbone acknowledge.
- wbm_dat_i  in  WBW  Wishbone read data.

Behaviour:
- Register map (byte offsets from BASE_ADR):
  - 0x00 DIVIDEND (W)
  - 0x04 DIVISOR (W)
  - 0x08 CTRL (W); bit0 = start
  - 0x0C STATUS (R); bit0 = done
  - 0x10 QUOTIENT (R)
  - 0x14 REMAINDER (R)
- All outputs are registered. Reset values: all outputs 0, except req_ready_o = 1. Internal registers are 0 and the FSM is in IDLE.
- Request handshake (req_valid_i & req_ready_o): capture both operands; go to WR_DVD next cycle.
- FSM sequence: IDLE -> WR_DVD -> WR_DVS -> WR_CTRL -> RD_STAT -> RD_QUO -> RD_REM -> RESP -> IDLE.
- Bus-state protocol:
  - Each bus state drives cyc = stb = 1, plus its adr/we/dat, and holds them stable until wbm_ack_i is sampled high.
  - The cycle after ack, cyc/stb drop for exactly one cycle (GAP) before the next bus state.
  - Read data is captured on the ack cycle.
- WR_CTRL writes 32'h1.
- RD_STAT polling:
  - On ack with wbm_dat_i[0] = 0: GAP, then re-issue RD_STAT (unbounded poll without the feature).
  - On ack with bit0 = 1: proceed to RD_QUO.
- Bus-cycle count with an ack-next-cycle slave and P status polls: (5+P) accesses, 2 cycles each.
- RESP:
  - rsp_valid_o = 1; quotient/remainder/err held stable until rsp_ready_i.
  - On the handshake cycle: rsp_valid_o -> 0, return to IDLE, req_ready_o -> 1 next cycle.
- No request is accepted while busy; req_ready_o = 0 from the handshake until the return to IDLE.
- Divisor = 0 is forwarded unchanged. Results are whatever the divider returns; no local check.
- Reset asserted mid-transaction:
  - cyc/stb drop asynchronously; the FSM goes to IDLE.
  - A pending response is discarded.
  - The slave may still be mid-operation; the next request re-writes all operands.
- wbm_ack_i while cyc is low: ignored.

Optional Feature:
- Macro: SERIAL_DIVIDER_WBM_TIMEOUT_EN.
- Defined:
  - A counter clears at each bus-state entry and increments every cycle stb is high without ack.
  - On reaching TMO_CYC: drop cyc/stb, skip to RESP with err_o = 1, quotient_o = remainder_o = 0.
  - The same counter also bounds total RD_STAT polling: it is not cleared between polls, only on entering the first RD_STAT.
  - err_o clears on the response handshake.
- Undefined: no counter; waits forever; err_o tied 0.

Test Plan:
- Single op, 1-cycle-ack slave model, done on first poll: request 100/7 -> write sequence adr 0x3000_0000 = 100, 0x3000_0004 = 7, 0x3000_0008 = 1; reads 0x3000_000C, 0x10, 0x14 -> rsp 14 r 2, err_o = 0; cyc low in every GAP cycle.
- Slow divider: STATUS returns 0 for 32 polls, then 1; request 0xFFFF_FFFF/1 -> exactly 33 STATUS reads -> rsp 0xFFFF_FFFF r 0.
- Ack wait states (ack 3 cycles after stb) -> adr/dat/we stable for all 3 cycles; results correct for 1000/33 -> 30 r 10.
- Response backpressure: hold rsp_ready_i = 0 for 10 cycles -> rsp_valid_o and data stable; req_ready_o = 0 throughout; new request accepted only after the handshake.
- Reset asserted during RD_STAT -> cyc/stb/rsp_valid_o = 0 immediately, req_ready_o = 1 after release; a following request 9/4 -> 2 r 1.
- (Feature defined, TMO_CYC = 16) slave never acks the DIVISOR write -> stb high for 16 cycles, then rsp_valid_o = 1, err_o = 1, quotient/remainder 0.
